kinase_ctrl_seq: RTL and testbench



---
 rtl/kinase_ctrl_seq_if.sv | 27 ++
 rtl/kinase_ctrl_seq.sv | 178 +++++++++++++++++
 tb/tb_kinase_ctrl_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/kinase_ctrl_seq_if.sv
// Actuation bus and handshake bundle between the assay host and the kinase
// control sequencer. The host drives start/hold/abort; the sequencer drives
// the valve, sieve and pump lines plus its status outputs.
interface kinase_ctrl_seq_if;
  logic        start;
  logic        hold;
  logic        abort;
  logic [12:0] c;
  logic [3:0]  s;
  logic [4:0]  p;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  phase;

  // Host side: issues commands and observes the bus
  modport master (
    output start, hold, abort,
    input  c, s, p, busy, done, aborted, phase
  );

  // Sequencer side: accepts commands and drives the bus
  modport slave (
    input  start, hold, abort,
    output c, s, p, busy, done, aborted, phase
  );
endinterface

// File: rtl/kinase_ctrl_seq.sv
// Assay recipe sequencer for the dual kinase-activity chip. Walks
// LOAD_A -> LOAD_B -> MIX -> INCUBATE -> WASH -> ELUTE -> DONE, drives the
// shared valve/sieve/pump bus with registered Moore outputs, and runs a
// six-step peristaltic pattern on p[2:0] during the pumped phases.
module kinase_ctrl_seq #(
  parameter int PUMP_DIV    = 4,
  parameter int LOAD_STEPS  = 12,
  parameter int MIX_STEPS   = 48,
  parameter int INC_CYCLES  = 1000,
  parameter int WASH_STEPS  = 24,
  parameter int ELUTE_STEPS = 12,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  kinase_ctrl_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_A   = 3'd1;
  localparam logic [2:0] S_LOAD_B   = 3'd2;
  localparam logic [2:0] S_MIX      = 3'd3;
  localparam logic [2:0] S_INCUBATE = 3'd4;
  localparam logic [2:0] S_WASH     = 3'd5;
  localparam logic [2:0] S_ELUTE    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  // Zero-length phases are stretched to one step/cycle so the recipe never stalls.
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(((PUMP_DIV    < 1) ? 1 : PUMP_DIV)    - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(((LOAD_STEPS  < 1) ? 1 : LOAD_STEPS)  - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(((MIX_STEPS   < 1) ? 1 : MIX_STEPS)   - 1);
  localparam logic [CNT_W-1:0] INC_LAST   = CNT_W'(((INC_CYCLES  < 1) ? 1 : INC_CYCLES)  - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(((WASH_STEPS  < 1) ? 1 : WASH_STEPS)  - 1);
  localparam logic [CNT_W-1:0] ELUTE_LAST = CNT_W'(((ELUTE_STEPS < 1) ? 1 : ELUTE_STEPS) - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] stepCnt_q, stepCnt_d;
  logic [CNT_W-1:0] divCnt_q, divCnt_d;
  logic [2:0]       pumpIdx_q, pumpIdx_d;
  logic [12:0]      c_q, c_d;
  logic [3:0]       s_q, s_d;
  logic [4:0]       p_q, p_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] stepLast;
  logic             pumped;
  logic             abortHit;

  // Phase sequencing: abort first, then DONE exit, then hold, then duration counting.
  always_comb begin
    state_d   = state_q;
    stepCnt_d = stepCnt_q;
    divCnt_d  = divCnt_q;
    pumpIdx_d = pumpIdx_q;
    abortHit  = 1'b0;
    pumped    = state_q inside {S_LOAD_A, S_LOAD_B, S_MIX, S_WASH, S_ELUTE};
    case (state_q)
      S_LOAD_A, S_LOAD_B: stepLast = LOAD_LAST;
      S_MIX:              stepLast = MIX_LAST;
      S_INCUBATE:         stepLast = INC_LAST;
      S_WASH:             stepLast = WASH_LAST;
      S_ELUTE:            stepLast = ELUTE_LAST;
      default:            stepLast = '0;
    endcase

    if (state_q == S_IDLE) begin
      if (bus.start && !bus.abort) begin
        state_d   = S_LOAD_A;
        stepCnt_d = '0;
        divCnt_d  = '0;
        pumpIdx_d = '0;
      end
    end else if (bus.abort) begin
      state_d   = S_IDLE;
      stepCnt_d = '0;
      divCnt_d  = '0;
      pumpIdx_d = '0;
      abortHit  = 1'b1;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (bus.hold) begin
      state_d = state_q;
    end else if (!pumped) begin
      if (stepCnt_q >= stepLast) begin
        state_d   = state_q + 3'd1;
        stepCnt_d = '0;
        divCnt_d  = '0;
        pumpIdx_d = '0;
      end else begin
        stepCnt_d = stepCnt_q + CNT_W'(1);
      end
    end else if (divCnt_q >= DIV_LAST) begin
      divCnt_d = '0;
      if (stepCnt_q >= stepLast) begin
        state_d   = state_q + 3'd1;
        stepCnt_d = '0;
        pumpIdx_d = '0;
      end else begin
        stepCnt_d = stepCnt_q + CNT_W'(1);
        pumpIdx_d = (pumpIdx_q == 3'd5) ? 3'd0 : pumpIdx_q + 3'd1;
      end
    end else begin
      divCnt_d = divCnt_q + CNT_W'(1);
    end
  end

  // Output decode from the upcoming state so registered outputs change on the entry edge.
  always_comb begin
    c_d       = '1;
    s_d       = '1;
    p_d       = '1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    aborted_d = abortHit;
    case (state_d)
      S_LOAD_A: c_d[1:0] = 2'b00;
      S_LOAD_B: c_d[3:2] = 2'b00;
      S_MIX: begin
        c_d[7:4] = 4'b0000;
        p_d[3]   = 1'b0;
      end
      S_WASH:   c_d[9:8] = 2'b00;
      S_ELUTE: begin
        c_d[12:10] = 3'b000;
        s_d        = 4'b0000;
        p_d[4]     = 1'b0;
      end
      default: c_d = '1;
    endcase
    if (state_d inside {S_LOAD_A, S_LOAD_B, S_MIX, S_WASH, S_ELUTE}) begin
      case (pumpIdx_d)
        3'd0:    p_d[2:0] = 3'b110;
        3'd1:    p_d[2:0] = 3'b010;
        3'd2:    p_d[2:0] = 3'b011;
        3'd3:    p_d[2:0] = 3'b001;
        3'd4:    p_d[2:0] = 3'b101;
        default: p_d[2:0] = 3'b100;
      endcase
    end
  end

  // State, counters and bus outputs; reset forces the safe all-closed pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stepCnt_q <= '0;
      divCnt_q  <= '0;
      pumpIdx_q <= '0;
      c_q       <= '1;
      s_q       <= '1;
      p_q       <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stepCnt_q <= stepCnt_d;
      divCnt_q  <= divCnt_d;
      pumpIdx_q <= pumpIdx_d;
      c_q       <= c_d;
      s_q       <= s_d;
      p_q       <= p_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.c       = c_q;
  assign bus.s       = s_q;
  assign bus.p       = p_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_kinase_ctrl_seq.sv
// Bench for kinase_ctrl_seq: directed recipe scenarios plus random
// start/hold/abort traffic, compared each cycle against a model that tracks
// only the current phase and the cycles elapsed in it.
module tb_kinase_ctrl_seq;

  localparam int DIV   = 2;
  localparam int LOADN = 2;
  localparam int MIXN  = 3;
  localparam int INCN  = 4;
  localparam int WASHN = 2;
  localparam int ELUTN = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  kinase_ctrl_seq_if busIf ();

  kinase_ctrl_seq #(
    .PUMP_DIV(DIV), .LOAD_STEPS(LOADN), .MIX_STEPS(MIXN), .INC_CYCLES(INCN),
    .WASH_STEPS(WASHN), .ELUTE_STEPS(ELUTN), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(busIf.slave)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int   mState;
  int   mEl;
  logic mAbortPulse;
  logic [2:0] pumpPat [6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

  int         phaseLog[$];
  logic [2:0] mixP[$];
  logic [2:0] entryP[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int phaseDur(input int st);
    case (st)
      1, 2:    return LOADN * DIV;
      3:       return MIXN * DIV;
      4:       return INCN;
      5:       return WASHN * DIV;
      6:       return ELUTN * DIV;
      default: return 1;
    endcase
  endfunction

  function automatic logic [27:0] modelOut();
    logic [12:0] c;
    logic [3:0]  s;
    logic [4:0]  p;
    c = '1;
    s = '1;
    p = '1;
    case (mState)
      1: c[1:0] = 2'b00;
      2: c[3:2] = 2'b00;
      3: begin c[7:4] = 4'b0000; p[3] = 1'b0; end
      5: c[9:8] = 2'b00;
      6: begin c[12:10] = 3'b000; s = 4'b0000; p[4] = 1'b0; end
      default: c = '1;
    endcase
    if (mState inside {1, 2, 3, 5, 6}) p[2:0] = pumpPat[(mEl / DIV) % 6];
    return {3'(mState), (mState != 0), (mState == 7), mAbortPulse, p, s, c};
  endfunction

  function automatic logic [27:0] dutOut();
    return {busIf.phase, busIf.busy, busIf.done, busIf.aborted, busIf.p, busIf.s, busIf.c};
  endfunction

  task automatic modelReset();
    mState = 0;
    mEl = 0;
    mAbortPulse = 1'b0;
  endtask

  task automatic modelAdvance(input logic st, input logic hd, input logic ab);
    mAbortPulse = 1'b0;
    if (mState == 0) begin
      if (st && !ab) begin mState = 1; mEl = 0; end
    end else if (ab) begin
      mState = 0; mEl = 0; mAbortPulse = 1'b1;
    end else if (mState == 7) begin
      mState = 0;
    end else if (!hd) begin
      mEl++;
      if (mEl >= phaseDur(mState)) begin mState++; mEl = 0; end
    end
  endtask

  // Drives one cycle of inputs, advances the model on the edge, compares after it
  task automatic applyStimulus(input logic st, input logic hd, input logic ab, input string tag);
    busIf.start = st;
    busIf.hold  = hd;
    busIf.abort = ab;
    @(posedge clk);
    modelAdvance(st, hd, ab);
    #1;
    checkOutput(tag, 32'(dutOut()), 32'(modelOut()));
  endtask

  // Runs one recipe from IDLE with an optional hold window and a stray start pulse
  task automatic runRecipe(input int holdFrom, input int holdTo, input int dupAt, output int lat);
    int prevPh;
    phaseLog.delete();
    mixP.delete();
    entryP.delete();
    applyStimulus(1'b1, 1'b0, 1'b0, "recipe_start");
    checkOutput("start_phase", 32'(busIf.phase), 32'd1);
    checkOutput("start_c", 32'(busIf.c), 32'h1FFC);
    checkOutput("start_p", 32'(busIf.p[2:0]), 32'b110);
    phaseLog.push_back(int'(busIf.phase));
    prevPh = 1;
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      applyStimulus((i == dupAt), (i >= holdFrom && i < holdTo), 1'b0, "recipe_cycle");
      phaseLog.push_back(int'(busIf.phase));
      if (busIf.phase == 3'd3) mixP.push_back(busIf.p[2:0]);
      if (int'(busIf.phase) != prevPh && busIf.phase inside {3'd2, 3'd3, 3'd5, 3'd6})
        entryP.push_back(busIf.p[2:0]);
      prevPh = int'(busIf.phase);
      if (busIf.done && lat < 0) lat = i;
      if (busIf.phase == 3'd0 && !busIf.busy) break;
    end
    checkOutput("recipe_finished", 32'(busIf.busy), 32'd0);
  endtask

  initial begin
    int lat;
    int lens[8];
    int expLens[8];
    logic [2:0] expMix[6];
    logic doneSeen;

    expLens = '{0, 4, 4, 6, 4, 4, 4, 1};
    expMix  = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b011, 3'b011};

    // Reset values
    busIf.start = 1'b0;
    busIf.hold  = 1'b0;
    busIf.abort = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_state", 32'(dutOut()), {4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h1F, 4'hF, 13'h1FFF});
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, "idle");

    // Nominal recipe: latency, phase lengths, pump sequence
    runRecipe(1000, 1000, -1, lat);
    checkOutput("done_latency", 32'(lat), 32'd26);
    lens = '{default: 0};
    foreach (phaseLog[k]) if (phaseLog[k] >= 1 && phaseLog[k] <= 7) lens[phaseLog[k]]++;
    for (int ph = 1; ph <= 7; ph++)
      checkOutput($sformatf("len_phase%0d", ph), 32'(lens[ph]), 32'(expLens[ph]));
    checkOutput("mix_p_count", 32'(mixP.size()), 32'd6);
    for (int k = 0; k < 6 && k < mixP.size(); k++)
      checkOutput($sformatf("mix_p%0d", k), 32'(mixP[k]), 32'(expMix[k]));
    checkOutput("entry_count", 32'(entryP.size()), 32'd4);
    foreach (entryP[k]) checkOutput($sformatf("entry_p%0d", k), 32'(entryP[k]), 32'b110);

    // Asynchronous reset in the middle of MIX, then a full rerun
    applyStimulus(1'b1, 1'b0, 1'b0, "rst_start");
    for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, "rst_run");
    checkOutput("rst_in_mix", 32'(busIf.phase), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_async", 32'(dutOut()), {4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 5'h1F, 4'hF, 13'h1FFF});
    @(negedge clk);
    rst_n = 1'b1;
    runRecipe(1000, 1000, -1, lat);
    checkOutput("rerun_latency", 32'(lat), 32'd26);

    // Five hold cycles inside INCUBATE push done out by five
    runRecipe(16, 21, -1, lat);
    checkOutput("hold_latency", 32'(lat), 32'd31);

    // Abort together with hold on the last WASH cycle
    applyStimulus(1'b1, 1'b0, 1'b0, "abort_start");
    for (int i = 1; i <= 21; i++) applyStimulus(1'b0, 1'b0, 1'b0, "abort_run");
    checkOutput("abort_in_wash", 32'(busIf.phase), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, "abort_hit");
    checkOutput("abort_phase", 32'(busIf.phase), 32'd0);
    checkOutput("abort_pulse", 32'(busIf.aborted), 32'd1);
    checkOutput("abort_safe", 32'({busIf.c, busIf.s, busIf.p}), 32'h3FFFFF);
    doneSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, "abort_after");
      if (i == 0) checkOutput("abort_pulse_end", 32'(busIf.aborted), 32'd0);
      if (busIf.done) doneSeen = 1'b1;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

    // Stray start while busy, and start with abort in IDLE
    runRecipe(1000, 1000, 5, lat);
    checkOutput("dup_start_latency", 32'(lat), 32'd26);
    applyStimulus(1'b1, 1'b0, 1'b1, "idle_start_abort");
    checkOutput("idle_sa_phase", 32'(busIf.phase), 32'd0);
    checkOutput("idle_sa_busy", 32'(busIf.busy), 32'd0);

    // Random command traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(3) == 0), ($urandom_range(7) == 0),
                    ($urandom_range(39) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
